// File: rtl/mkio_pkg.sv
// Shared definitions for the MKIO remote-terminal engine: command layout,
// status-word bits, FSM states and the status-word builder.
package mkio_pkg;
  localparam int unsigned WORD_W       = 16;
  localparam int unsigned ADDR_W       = 5;
  localparam int unsigned BUF_AW       = 10;
  localparam int unsigned STAT_ME_BIT  = 10;
  localparam int unsigned STAT_BCR_BIT = 4;

  localparam logic [ADDR_W-1:0] BCAST_ADDR = 5'd31;
  localparam logic [ADDR_W-1:0] MODE_SA_LO = 5'd0;
  localparam logic [ADDR_W-1:0] MODE_SA_HI = 5'd31;

  // Command word layout: [15:11] RT, [10] T/R, [9:5] SA, [4:0] WC
  typedef struct packed {
    logic [ADDR_W-1:0] rt;
    logic              tr;
    logic [ADDR_W-1:0] sa;
    logic [ADDR_W-1:0] wc;
  } cmd_t;

  typedef enum logic [3:0] {
    IDLE, RXD, DELAY, SEND, SEND_HI, SEND_LO, TXD, TXD_WAIT, TXD_LAT, DONE
  } state_t;

  function automatic logic [WORD_W-1:0] status_word(input logic [ADDR_W-1:0] rt,
                                                    input logic me, input logic bcr);
    logic [WORD_W-1:0] w;
    w = {rt, 11'd0};
    w[STAT_ME_BIT]  = me;
    w[STAT_BCR_BIT] = bcr;
    return w;
  endfunction
endpackage

// File: rtl/mkio_cmd_decode.sv
// Combinational command-word decode: address/broadcast acceptance, mode-code
// detection and subaddress legality against the receive/transmit masks.
module mkio_cmd_decode
  import mkio_pkg::*;
#(
  parameter logic [ADDR_W-1:0] ADDRESS    = 5'd1,
  parameter logic [31:0]       RX_SA_MASK = 32'h0000_0028,
  parameter logic [31:0]       TX_SA_MASK = 32'h0000_0028,
  parameter bit                BCAST_EN   = 1'b1
) (
  input  logic              valid,
  input  logic [WORD_W-1:0] word,
  output logic              accept_c,
  output logic              bcast_c,
  output logic              mode_c,
  output logic              illegal_c,
  output logic              tr_c,
  output logic [ADDR_W-1:0] sa_c,
  output logic [ADDR_W-1:0] wc_c
);
  cmd_t        cmd;
  logic [31:0] mask;

  always_comb begin
    cmd       = cmd_t'(word);
    tr_c      = cmd.tr;
    sa_c      = cmd.sa;
    wc_c      = cmd.wc;
    mask      = cmd.tr ? TX_SA_MASK : RX_SA_MASK;
    mode_c    = (cmd.sa == MODE_SA_LO) || (cmd.sa == MODE_SA_HI);
    bcast_c   = BCAST_EN && (cmd.rt == BCAST_ADDR) && !cmd.tr;
    accept_c  = valid && ((cmd.rt == ADDRESS) || bcast_c);
    illegal_c = !mode_c && !mask[cmd.sa];
  end
endmodule

// File: rtl/mkio_rt_engine.sv
// MIL-STD-1553 remote-terminal message engine: runs receive/transmit messages
// between the Manchester codec and the shared message buffer.
module mkio_rt_engine
  import mkio_pkg::*;
#(
  parameter logic [ADDR_W-1:0] ADDRESS    = 5'd1,
  parameter logic [31:0]       RX_SA_MASK = 32'h0000_0028,
  parameter logic [31:0]       TX_SA_MASK = 32'h0000_0028,
  parameter bit                BCAST_EN   = 1'b1,
  parameter int unsigned       RESP_DELAY = 8,
  parameter int unsigned       TIMEOUT    = 1023
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_done,
  input  logic [WORD_W-1:0] rx_data,
  input  logic              rx_cd,
  input  logic              p_error,
  output logic              tx_ready,
  output logic [WORD_W-1:0] tx_data,
  output logic              tx_cd,
  input  logic              tx_busy,
  output logic [BUF_AW-1:0] buf_addr,
  output logic [WORD_W-1:0] buf_wdata,
  output logic              buf_we,
  output logic              buf_re,
  input  logic [WORD_W-1:0] buf_rdata,
  output logic              msg_done,
  output logic              msg_err,
  output logic [ADDR_W-1:0] msg_sa,
  output logic              msg_tr
);
  localparam int unsigned      TMR_W      = 10;
  localparam logic [TMR_W-1:0] DELAY_LAST = TMR_W'(RESP_DELAY - 2);
  localparam logic [TMR_W-1:0] GAP_LAST   = TMR_W'(TIMEOUT - 1);

  state_t            state, state_nx, branch_c;
  logic [ADDR_W-1:0] sa, sa_nx, wc, wc_nx, idx, idx_nx;
  logic              tr, tr_nx, bcast, bcast_nx, err, err_nx;
  logic              me, me_nx, bcr, bcr_nx, txn, txn_nx;
  logic [TMR_W-1:0]  timer, timer_nx;
  logic              tx_ready_nx, tx_cd_nx, buf_we_nx, buf_re_nx;
  logic              msg_done_nx, msg_err_nx, msg_tr_nx;
  logic [WORD_W-1:0] tx_data_nx, buf_wdata_nx;
  logic [BUF_AW-1:0] buf_addr_nx;
  logic [ADDR_W-1:0] msg_sa_nx;

  logic              cmd_valid_c, accept_c, bcast_c, mode_c, illegal_c, tr_c;
  logic [ADDR_W-1:0] sa_c, wc_c;
  logic              word_c, last_c, gap_c;

  assign cmd_valid_c = rx_done && !rx_cd && !p_error;

  mkio_cmd_decode #(
    .ADDRESS(ADDRESS), .RX_SA_MASK(RX_SA_MASK),
    .TX_SA_MASK(TX_SA_MASK), .BCAST_EN(BCAST_EN)
  ) u_dec (
    .valid(cmd_valid_c), .word(rx_data), .accept_c(accept_c), .bcast_c(bcast_c),
    .mode_c(mode_c), .illegal_c(illegal_c), .tr_c(tr_c), .sa_c(sa_c), .wc_c(wc_c)
  );

  // Message-level conditions; WC=0 wraps to a last index of 31 (32 words)
  always_comb begin
    word_c = rx_done && rx_cd;
    last_c = (idx == ADDR_W'(wc - 5'd1));
    gap_c  = (timer == GAP_LAST);
    if (bcast_c && (mode_c || illegal_c))        branch_c = DONE;
    else if (!tr_c && !mode_c && !illegal_c)     branch_c = RXD;
    else                                         branch_c = DELAY;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      sa <= '0; tr <= 1'b0; wc <= '0; idx <= '0; timer <= '0;
      bcast <= 1'b0; err <= 1'b0; me <= 1'b0; bcr <= 1'b0; txn <= 1'b0;
      tx_ready <= 1'b0; tx_data <= '0; tx_cd <= 1'b0;
      buf_addr <= '0; buf_wdata <= '0; buf_we <= 1'b0; buf_re <= 1'b0;
      msg_done <= 1'b0; msg_err <= 1'b0; msg_sa <= '0; msg_tr <= 1'b0;
    end else begin
      state <= state_nx;
      sa <= sa_nx; tr <= tr_nx; wc <= wc_nx; idx <= idx_nx; timer <= timer_nx;
      bcast <= bcast_nx; err <= err_nx; me <= me_nx; bcr <= bcr_nx; txn <= txn_nx;
      tx_ready <= tx_ready_nx; tx_data <= tx_data_nx; tx_cd <= tx_cd_nx;
      buf_addr <= buf_addr_nx; buf_wdata <= buf_wdata_nx;
      buf_we <= buf_we_nx; buf_re <= buf_re_nx;
      msg_done <= msg_done_nx; msg_err <= msg_err_nx;
      msg_sa <= msg_sa_nx; msg_tr <= msg_tr_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (accept_c) state_nx = branch_c;
      RXD: begin
        if (accept_c) state_nx = branch_c;
        else if (word_c) begin
          if (p_error)     state_nx = DONE;
          else if (last_c) state_nx = bcast ? DONE : DELAY;
        end else if (gap_c) state_nx = DONE;
      end
      DELAY:    if (timer == DELAY_LAST) state_nx = SEND;
      SEND:     if (!tx_busy) state_nx = SEND_HI;
      SEND_HI:  if (tx_busy) state_nx = SEND_LO;
      SEND_LO:  if (!tx_busy) state_nx = txn ? TXD : DONE;
      TXD:      state_nx = TXD_WAIT;
      TXD_WAIT: state_nx = TXD_LAT;
      TXD_LAT:  state_nx = SEND;
      DONE:     state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_comb begin
    sa_nx = sa; tr_nx = tr; wc_nx = wc; idx_nx = idx;
    timer_nx = timer + TMR_W'(1);
    bcast_nx = bcast; err_nx = err; me_nx = me; bcr_nx = bcr; txn_nx = txn;
    tx_ready_nx = 1'b0; tx_data_nx = tx_data; tx_cd_nx = tx_cd;
    buf_addr_nx = buf_addr; buf_wdata_nx = buf_wdata;
    buf_we_nx = 1'b0; buf_re_nx = 1'b0;
    msg_done_nx = 1'b0; msg_err_nx = msg_err; msg_sa_nx = msg_sa; msg_tr_nx = msg_tr;
    if ((state == IDLE || state == RXD) && accept_c) begin
      // A new command during RXD closes the running message as aborted
      if (state == RXD) begin
        msg_done_nx = 1'b1; msg_err_nx = 1'b1; msg_sa_nx = sa; msg_tr_nx = tr;
      end
      sa_nx = sa_c; tr_nx = tr_c; wc_nx = wc_c; idx_nx = '0; timer_nx = '0;
      bcast_nx = bcast_c; err_nx = illegal_c; me_nx = me || illegal_c;
      txn_nx = tr_c && !mode_c && !illegal_c;
    end else begin
      case (state)
        RXD: begin
          if (word_c) begin
            if (p_error) begin
              me_nx = 1'b1; err_nx = 1'b1;
            end else begin
              buf_we_nx = 1'b1; buf_addr_nx = {sa, idx}; buf_wdata_nx = rx_data;
              idx_nx = idx + 5'd1; timer_nx = '0;
            end
          end else if (gap_c) begin
            me_nx = 1'b1; err_nx = 1'b1;
          end
        end
        DELAY: if (timer == DELAY_LAST) begin
          tx_data_nx = status_word(ADDRESS, me, bcr); tx_cd_nx = 1'b0;
        end
        SEND: if (!tx_busy) begin
          tx_ready_nx = 1'b1;
          if (!tx_cd) begin
            me_nx = 1'b0; bcr_nx = 1'b0;
          end
        end
        TXD: begin
          buf_re_nx = 1'b1; buf_addr_nx = {sa, idx};
        end
        TXD_LAT: begin
          tx_data_nx = buf_rdata; tx_cd_nx = 1'b1; idx_nx = idx + 5'd1;
          if (last_c) txn_nx = 1'b0;
        end
        DONE: begin
          msg_done_nx = 1'b1; msg_err_nx = err; msg_sa_nx = sa; msg_tr_nx = tr;
          if (bcast) bcr_nx = 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mkio_rt_engine.sv
// Directed self-checking bench for mkio_rt_engine with a buffer and a
// transmitter model.
module tb_mkio_rt_engine;
  logic        clk = 1'b0;
  logic        reset, rx_done, rx_cd, p_error, tx_ready, tx_cd, tx_busy;
  logic [15:0] rx_data, tx_data, buf_wdata, buf_rdata;
  logic [9:0]  buf_addr;
  logic        buf_we, buf_re, msg_done, msg_err, msg_tr;
  logic [4:0]  msg_sa;
  logic [53:0] outs_v;

  int tests = 0, fails = 0;
  int wr_cnt = 0, rd_cnt = 0, tx_cnt = 0, done_cnt = 0, busy_left = 0;
  logic [15:0] rmem [0:1023];
  logic [15:0] wmem [0:1023];

  always #5 clk = ~clk;

  mkio_rt_engine dut (
    .clk(clk), .reset(reset), .rx_done(rx_done), .rx_data(rx_data), .rx_cd(rx_cd),
    .p_error(p_error), .tx_ready(tx_ready), .tx_data(tx_data), .tx_cd(tx_cd),
    .tx_busy(tx_busy), .buf_addr(buf_addr), .buf_wdata(buf_wdata), .buf_we(buf_we),
    .buf_re(buf_re), .buf_rdata(buf_rdata), .msg_done(msg_done), .msg_err(msg_err),
    .msg_sa(msg_sa), .msg_tr(msg_tr)
  );

  assign outs_v  = {tx_ready, tx_data, tx_cd, buf_addr, buf_wdata, buf_we, buf_re,
                    msg_done, msg_err, msg_sa, msg_tr};
  assign tx_busy = (busy_left != 0);

  // Buffer, transmitter (busy for 5 clocks per word) and event counters
  always @(posedge clk) begin
    if (buf_re) begin
      buf_rdata <= rmem[buf_addr];
      rd_cnt    <= rd_cnt + 1;
    end
    if (buf_we) begin
      wmem[buf_addr] <= buf_wdata;
      wr_cnt         <= wr_cnt + 1;
    end
    if (msg_done) done_cnt <= done_cnt + 1;
    if (tx_ready) begin
      tx_cnt    <= tx_cnt + 1;
      busy_left <= 5;
    end else if (busy_left != 0) begin
      busy_left <= busy_left - 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [15:0] w, input logic cd, input logic pe);
    rx_data = w; rx_cd = cd; p_error = pe; rx_done = 1'b1;
    tick();
    rx_done = 1'b0; p_error = 1'b0;
  endtask

  task automatic expect_tx(input string tag, input logic [15:0] w, input logic cd,
                           input int lat_exp);
    int lat = 0;
    while (tx_ready !== 1'b1 && lat < 2000) begin
      tick();
      lat++;
    end
    chk({tag, "_seen"}, 64'(tx_ready), 64'd1);
    chk({tag, "_word"}, 64'(tx_data), 64'(w));
    chk({tag, "_cd"}, 64'(tx_cd), 64'(cd));
    chk({tag, "_busy"}, 64'(tx_busy), 64'd0);
    if (lat_exp >= 0) chk({tag, "_lat"}, 64'(lat), 64'(lat_exp));
    tick();
  endtask

  task automatic expect_done(input string tag, input logic err, input logic [4:0] sa,
                             input logic tr, input int lat_exp);
    int lat = 0;
    while (msg_done !== 1'b1 && lat < 2000) begin
      tick();
      lat++;
    end
    chk({tag, "_done"}, 64'(msg_done), 64'd1);
    chk({tag, "_err"}, 64'(msg_err), 64'(err));
    chk({tag, "_sa"}, 64'(msg_sa), 64'(sa));
    chk({tag, "_tr"}, 64'(msg_tr), 64'(tr));
    if (lat_exp >= 0) chk({tag, "_lat"}, 64'(lat), 64'(lat_exp));
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, r0, t0, d0;
    reset = 1'b0; rx_done = 1'b0; rx_data = '0; rx_cd = 1'b0; p_error = 1'b0;
    for (int i = 0; i < 1024; i++) rmem[i] = 16'(i);
    rmem[160] = 16'hAAAA;
    rmem[161] = 16'h5555;
    repeat (3) tick();
    chk("reset_outs", 64'(outs_v), 64'd0);
    reset = 1'b1;
    tick();

    // Receive SA3 WC3: writes to 96..98, status 8 clocks after last word
    w0 = wr_cnt; r0 = rd_cnt;
    send(16'h0863, 1'b0, 1'b0);
    send(16'h1111, 1'b1, 1'b0);
    send(16'h2222, 1'b1, 1'b0);
    send(16'h3333, 1'b1, 1'b0);
    expect_tx("rx_status", 16'h0800, 1'b0, 8);
    expect_done("rx_msg", 1'b0, 5'd3, 1'b0, -1);
    chk("rx_wcnt", 64'(wr_cnt - w0), 64'd3);
    chk("rx_rcnt", 64'(rd_cnt - r0), 64'd0);
    chk("rx_w96", 64'(wmem[96]), 64'h1111);
    chk("rx_w97", 64'(wmem[97]), 64'h2222);
    chk("rx_w98", 64'(wmem[98]), 64'h3333);

    // Transmit SA5 WC2 from 160/161
    w0 = wr_cnt; r0 = rd_cnt;
    send(16'h0CA2, 1'b0, 1'b0);
    expect_tx("tx_status", 16'h0800, 1'b0, 8);
    expect_tx("tx_d0", 16'hAAAA, 1'b1, -1);
    expect_tx("tx_d1", 16'h5555, 1'b1, -1);
    expect_done("tx_msg", 1'b0, 5'd5, 1'b1, -1);
    chk("tx_rcnt", 64'(rd_cnt - r0), 64'd2);
    chk("tx_wcnt", 64'(wr_cnt - w0), 64'd0);

    // Broadcast receive: written, silent, BCR in next status
    t0 = tx_cnt;
    send(16'hF861, 1'b0, 1'b0);
    send(16'hBEEF, 1'b1, 1'b0);
    expect_done("bc_msg", 1'b0, 5'd3, 1'b0, -1);
    repeat (20) tick();
    chk("bc_no_tx", 64'(tx_cnt), 64'(t0));
    chk("bc_w96", 64'(wmem[96]), 64'hBEEF);
    send(16'h08A1, 1'b0, 1'b0);
    send(16'h1234, 1'b1, 1'b0);
    expect_tx("bcr_status", 16'h0810, 1'b0, 8);
    expect_done("bcr_msg", 1'b0, 5'd5, 1'b0, -1);
    chk("bcr_w160", 64'(wmem[160]), 64'h1234);

    // Masked SA7: ME status, no buffer access; then clean again
    w0 = wr_cnt; r0 = rd_cnt;
    send(16'h08E1, 1'b0, 1'b0);
    expect_tx("ill_status", 16'h0C00, 1'b0, 8);
    expect_done("ill_msg", 1'b1, 5'd7, 1'b0, -1);
    chk("ill_nobuf", 64'((wr_cnt - w0) + (rd_cnt - r0)), 64'd0);
    send(16'h0801, 1'b0, 1'b0);
    expect_tx("mc_status", 16'h0800, 1'b0, 8);
    expect_done("mc_msg", 1'b0, 5'd0, 1'b0, -1);

    // Parity error on word 2: only word 1 written, silent, ME next time
    w0 = wr_cnt; t0 = tx_cnt;
    send(16'h0862, 1'b0, 1'b0);
    send(16'h7777, 1'b1, 1'b0);
    send(16'h8888, 1'b1, 1'b1);
    expect_done("pe_msg", 1'b1, 5'd3, 1'b0, -1);
    repeat (20) tick();
    chk("pe_wcnt", 64'(wr_cnt - w0), 64'd1);
    chk("pe_w96", 64'(wmem[96]), 64'h7777);
    chk("pe_w97", 64'(wmem[97]), 64'h2222);
    chk("pe_no_tx", 64'(tx_cnt), 64'(t0));
    send(16'h0801, 1'b0, 1'b0);
    expect_tx("pe_me_status", 16'h0C00, 1'b0, 8);
    expect_done("pe_mc_msg", 1'b0, 5'd0, 1'b0, -1);

    // New command during RXD aborts the running message on the same clock
    send(16'h0864, 1'b0, 1'b0);
    send(16'h4444, 1'b1, 1'b0);
    send(16'h0801, 1'b0, 1'b0);
    expect_done("abort_msg", 1'b1, 5'd3, 1'b0, 0);
    expect_tx("abort_status", 16'h0800, 1'b0, 7);
    expect_done("abort_mc_msg", 1'b0, 5'd0, 1'b0, -1);

    // Data stops after word 1: timeout TIMEOUT+1 clocks later
    send(16'h0864, 1'b0, 1'b0);
    send(16'h5151, 1'b1, 1'b0);
    expect_done("to_msg", 1'b1, 5'd3, 1'b0, 1024);

    // Reset mid-RXD: outputs cleared, message abandoned silently
    send(16'h0864, 1'b0, 1'b0);
    send(16'h6161, 1'b1, 1'b0);
    repeat (3) tick();
    d0 = done_cnt;
    reset = 1'b0;
    #1;
    chk("rst_outs", 64'(outs_v), 64'd0);
    tick();
    tick();
    reset = 1'b1;
    repeat (30) tick();
    chk("rst_no_done", 64'(done_cnt), 64'(d0));
    send(16'h0801, 1'b0, 1'b0);
    expect_tx("post_rst_status", 16'h0800, 1'b0, 8);
    expect_done("post_rst_msg", 1'b0, 5'd0, 1'b0, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
